// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: FETCH/ISSUE/HALT sequencer feeding decode
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [4:0]  HLT_OP   = 5'b11111
) (
    input  logic        T0,
    input  logic        rst,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    input  logic        mem_ready,
    input  logic        stall,
    input  logic        pc_ld,
    input  logic [15:0] pc_new,
    output logic [15:0] IR,
    output logic        ir_valid,
    output logic [15:0] PC,
    output logic        halted,
    output logic [7:0]  fetch_cnt
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } fetchState_t;

    fetchState_t state;

    // Address always tracks the PC register, so it is stable while memory waits.
    assign mem_addr = PC;

    always_ff @(posedge T0) begin
        if (rst) begin
            state     <= FETCH;
            PC        <= RESET_PC;
            IR        <= 16'h0000;
            ir_valid  <= 1'b0;
            halted    <= 1'b0;
            fetch_cnt <= 8'h00;
            mem_rd    <= 1'b1;
        end else begin
            // A consumed instruction is counted even when a redirect lands on the same edge.
            if (state == ISSUE && !stall)
                fetch_cnt <= fetch_cnt + 8'h01;

            if (pc_ld) begin
                state    <= FETCH;
                PC       <= pc_new;
                ir_valid <= 1'b0;
                halted   <= 1'b0;
                mem_rd   <= 1'b1;
            end else begin
                case (state)
                    FETCH: begin
                        if (mem_ready) begin
                            IR       <= mem_data;
                            ir_valid <= 1'b1;
                            PC       <= PC + 16'h0001;
                            state    <= ISSUE;
                            mem_rd   <= 1'b0;
                        end
                    end
                    ISSUE: begin
                        if (!stall) begin
                            ir_valid <= 1'b0;
                            if (IR[15:11] == HLT_OP) begin
                                state  <= HALT;
                                halted <= 1'b1;
                                mem_rd <= 1'b0;
                            end else begin
                                state  <= FETCH;
                                mem_rd <= 1'b1;
                            end
                        end
                    end
                    HALT: begin
                        mem_rd <= 1'b0;
                    end
                    default: begin
                        state  <= FETCH;
                        mem_rd <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed and randomized checks of instr_fetch against a behavioural model
module tb_instr_fetch;

    logic        T0 = 1'b0;
    logic        rst;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        stall;
    logic        pc_ld;
    logic [15:0] pc_new;
    logic [15:0] IR;
    logic        ir_valid;
    logic [15:0] PC;
    logic        halted;
    logic [7:0]  fetch_cnt;

    int checks = 0;
    int errors = 0;

    // Model: an instruction is either waiting for decode (mPend), fetching is stopped (mStop), or neither.
    logic [15:0] mPc;
    logic [15:0] mIr;
    logic        mPend;
    logic        mStop;
    logic [7:0]  mCnt;

    instr_fetch #(.RESET_PC(16'h0000), .HLT_OP(5'b11111)) dut (
        .T0(T0), .rst(rst), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_ready(mem_ready), .stall(stall), .pc_ld(pc_ld), .pc_new(pc_new), .IR(IR),
        .ir_valid(ir_valid), .PC(PC), .halted(halted), .fetch_cnt(fetch_cnt)
    );

    always #5 T0 = ~T0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelStep();
        if (rst) begin
            mPc = 16'h0000; mIr = 16'h0000; mPend = 1'b0; mStop = 1'b0; mCnt = 8'h00;
        end else begin
            if (mPend && !stall) mCnt = mCnt + 8'h01;
            if (pc_ld) begin
                mPc = pc_new; mPend = 1'b0; mStop = 1'b0;
            end else if (mStop) begin
                mStop = 1'b1;
            end else if (mPend) begin
                if (!stall) begin
                    mPend = 1'b0;
                    mStop = (mIr[15:11] == 5'b11111);
                end
            end else if (mem_ready) begin
                mIr = mem_data; mPend = 1'b1; mPc = mPc + 16'h0001;
            end
        end
    endtask

    task automatic checkAll();
        chk("mem_rd", {31'b0, mem_rd}, {31'b0, !mPend && !mStop});
        chk("mem_addr", {16'b0, mem_addr}, {16'b0, mPc});
        chk("PC", {16'b0, PC}, {16'b0, mPc});
        chk("IR", {16'b0, IR}, {16'b0, mIr});
        chk("ir_valid", {31'b0, ir_valid}, {31'b0, mPend});
        chk("halted", {31'b0, halted}, {31'b0, mStop});
        chk("fetch_cnt", {24'b0, fetch_cnt}, {24'b0, mCnt});
    endtask

    // Inputs are set at the falling edge; the model advances with the rising edge.
    task automatic step();
        modelStep();
        @(posedge T0);
        @(negedge T0);
        checkAll();
    endtask

    task automatic idle();
        rst = 1'b0; mem_ready = 1'b0; stall = 1'b0; pc_ld = 1'b0;
        pc_new = 16'h0000; mem_data = 16'h0000;
    endtask

    initial begin
        mPc = 16'h0; mIr = 16'h0; mPend = 1'b0; mStop = 1'b0; mCnt = 8'h0;
        idle();

        // Reset state and basic fetch
        rst = 1'b1; pc_ld = 1'b1; pc_new = 16'h1234; mem_ready = 1'b1; mem_data = 16'h5555;
        step();
        chk("rst_mem_rd", {31'b0, mem_rd}, 32'h1);
        chk("rst_addr", {16'b0, mem_addr}, 32'h0);
        chk("rst_ir", {16'b0, IR}, 32'h0);
        idle(); mem_ready = 1'b1; mem_data = 16'h0020;
        step();
        chk("basic_ir", {16'b0, IR}, 32'h0020);
        chk("basic_valid", {31'b0, ir_valid}, 32'h1);
        chk("basic_pc", {16'b0, PC}, 32'h0001);
        idle();
        step();
        chk("basic_cnt", {24'b0, fetch_cnt}, 32'h01);
        chk("basic_next_rd", {31'b0, mem_rd}, 32'h1);
        chk("basic_next_addr", {16'b0, mem_addr}, 32'h0001);

        // Memory wait then decode stall
        rst = 1'b1; step(); idle();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_addr", {16'b0, mem_addr}, 32'h0000);
            chk("wait_rd", {31'b0, mem_rd}, 32'h1);
        end
        mem_ready = 1'b1; mem_data = 16'h1234; stall = 1'b1;
        step();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_ir", {16'b0, IR}, 32'h1234);
            chk("stall_valid", {31'b0, ir_valid}, 32'h1);
            chk("stall_rd", {31'b0, mem_rd}, 32'h0);
            chk("stall_cnt", {24'b0, fetch_cnt}, 32'h00);
        end
        stall = 1'b0;
        step();
        chk("unstall_cnt", {24'b0, fetch_cnt}, 32'h01);

        // Redirect colliding with memory data
        pc_ld = 1'b1; pc_new = 16'h0005; step();
        pc_new = 16'h0040; mem_ready = 1'b1; mem_data = 16'hABCD;
        step();
        chk("coll_ir", {16'b0, IR}, 32'h1234);
        chk("coll_addr", {16'b0, mem_addr}, 32'h0040);
        chk("coll_valid", {31'b0, ir_valid}, 32'h0);

        // Halt and restart
        idle(); mem_ready = 1'b1; mem_data = 16'hF800; step();
        mem_ready = 1'b0; step();
        chk("halt_flag", {31'b0, halted}, 32'h1);
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("halt_rd", {31'b0, mem_rd}, 32'h0);
        end
        idle(); pc_ld = 1'b1; pc_new = 16'h0010; step();
        chk("unhalt_flag", {31'b0, halted}, 32'h0);
        chk("unhalt_rd", {31'b0, mem_rd}, 32'h1);
        chk("unhalt_addr", {16'b0, mem_addr}, 32'h0010);

        // PC and counter wrap
        idle(); rst = 1'b1; step();
        idle(); pc_ld = 1'b1; pc_new = 16'hFFFF; step();
        idle(); mem_ready = 1'b1; mem_data = 16'h0021; step();
        chk("wrap_pc", {16'b0, PC}, 32'h0000);
        for (int i = 0; i < 255; i++) begin
            mem_ready = 1'b0; step();
            mem_ready = 1'b1; mem_data = 16'(i); step();
        end
        mem_ready = 1'b0; step();
        chk("wrap_cnt", {24'b0, fetch_cnt}, 32'h00);

        // Reset while stalled in issue
        mem_ready = 1'b1; mem_data = 16'h7777; stall = 1'b1; step();
        rst = 1'b1; step();
        chk("rststall_valid", {31'b0, ir_valid}, 32'h0);
        chk("rststall_ir", {16'b0, IR}, 32'h0);
        chk("rststall_pc", {16'b0, PC}, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            mem_ready = $urandom_range(0, 1) == 1;
            stall = $urandom_range(0, 2) == 0;
            pc_ld = $urandom_range(0, 15) == 0;
            pc_new = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            mem_data = 16'($urandom);
            if ($urandom_range(0, 5) == 0) mem_data[15:11] = 5'b11111;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
